// File: rtl/dbg_trace_tx_pkg.sv
// dbg_trace_tx_pkg: formatter FSM states, drop-marker character and hex-to-ASCII helper.
package dbg_trace_tx_pkg;
  typedef enum logic [2:0] {S_IDLE, S_TAG, S_HEX, S_SEP, S_MARK} state_e;
  localparam logic [7:0] MARK_CHAR = 8'h21;
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return nib < 4'd10 ? 8'h30 + {4'h0, nib} : 8'h57 + {4'h0, nib};
  endfunction
endpackage

// File: rtl/dbg_trace_tx_fifo.sv
// dbg_trace_tx_fifo: synchronous FIFO, all DEPTH entries usable, push+pop allowed together at full.
module dbg_trace_tx_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] level_q;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wp_q <= '0;
      rp_q <= '0;
      level_q <= '0;
    end else begin
      wp_q <= push ? wp_q + 1'b1 : wp_q;
      rp_q <= pop ? rp_q + 1'b1 : rp_q;
      level_q <= level_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // At full with a simultaneous pop, wp==rp: the head is read before the write lands.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= wdata;
  end
  assign rdata = mem_q[rp_q];
  assign level = level_q;
endmodule

// File: rtl/dbg_trace_tx.sv
// dbg_trace_tx: multi-channel trace arbiter + FIFO + ASCII hex formatter driving a uart byte port.
// Define DBG_DROPMARK_EN to emit a "!<hex count>" marker after a record whenever drops occurred.
module dbg_trace_tx
  import dbg_trace_tx_pkg::*;
#(
  parameter int         NCHAN    = 2,
  parameter int         DATA_W   = 16,
  parameter int         DEPTH    = 32,
  parameter logic [7:0] SEP_CHAR = 8'h0a
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NCHAN-1:0]        dbg_valid,
  input  logic [NCHAN*DATA_W-1:0] dbg_data,
  output logic                    tx_we,
  output logic [7:0]              tx_data,
  input  logic                    tx_wait,
  output logic                    idle,
  output logic [$clog2(DEPTH):0]  level,
  output logic [7:0]              drop_cnt
);
  localparam int PW = DATA_W - 8;
  localparam int NDIG = PW / 4;
  localparam int CW = $clog2(NDIG) + 2;
  localparam int LW = $clog2(DEPTH) + 1;
  state_e state_q, state_d;
  logic [7:0] tag_q, tag_d, snap_q, snap_d, drop_q, drop_d;
  logic [PW-1:0] pay_q, pay_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] win_data, head;
  logic [3:0] n_valid, n_drop;
  logic [8:0] drop_sum;
  logic any, push, pop, acc, rec_end, clr;
  always_comb begin
    win_data = '0;
    n_valid = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      win_data = dbg_valid[i] ? dbg_data[i*DATA_W +: DATA_W] : win_data;
      n_valid = n_valid + 4'(dbg_valid[i]);
    end
  end
  assign any = |dbg_valid;
  assign pop = state_q == S_IDLE && level != '0;
  assign push = any && (level < LW'(DEPTH) || pop);
  assign n_drop = (any ? n_valid - 4'd1 : 4'd0) + 4'(any && !push);
  assign drop_sum = (clr ? 9'd0 : {1'b0, drop_q}) + 9'(n_drop);
  assign drop_d = drop_sum[8] ? 8'hff : drop_sum[7:0];
  dbg_trace_tx_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .resetn(resetn),
    .push  (push),
    .pop   (pop),
    .wdata (win_data),
    .rdata (head),
    .level (level)
  );
  assign tx_we = state_q != S_IDLE;
  assign acc = tx_we && !tx_wait;
  assign idle = state_q == S_IDLE && level == '0;
  assign drop_cnt = drop_q;
  always_comb begin
    state_d = state_q;
    tag_d = tag_q;
    pay_d = pay_q;
    cnt_d = cnt_q;
    snap_d = snap_q;
    clr = 1'b0;
    rec_end = 1'b0;
    case (state_q)
      S_IDLE: if (pop) begin
        {tag_d, pay_d} = head;
        state_d = S_TAG;
      end
      S_TAG: if (acc) begin
        cnt_d = CW'(NDIG - 1);
        state_d = S_HEX;
      end
      S_HEX: if (acc) begin
        pay_d = pay_q << 4;
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_q != '0 ? S_HEX : S_SEP;
        rec_end = cnt_q == '0 && SEP_CHAR == 8'h00;
      end
      S_SEP: rec_end = acc;
      S_MARK: if (acc) begin
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CW'(3) || (cnt_q == CW'(2) && SEP_CHAR == 8'h00) ? S_IDLE : S_MARK;
      end
      default: state_d = S_IDLE;
    endcase
    if (rec_end) state_d = S_IDLE;
`ifdef DBG_DROPMARK_EN
    if (rec_end && drop_q != '0) begin
      state_d = S_MARK;
      snap_d = drop_q;
      clr = 1'b1;
      cnt_d = '0;
    end
`endif
  end
  always_comb begin
    tx_data = 8'h00;
    case (state_q)
      S_TAG:   tx_data = tag_q;
      S_HEX:   tx_data = hex_ascii(pay_q[PW-1 -: 4]);
      S_SEP:   tx_data = SEP_CHAR;
      S_MARK:  tx_data = cnt_q == '0 ? MARK_CHAR : cnt_q == CW'(1) ? hex_ascii(snap_q[7:4]) :
                         cnt_q == CW'(2) ? hex_ascii(snap_q[3:0]) : SEP_CHAR;
      default: tx_data = 8'h00;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      tag_q <= '0;
      pay_q <= '0;
      cnt_q <= '0;
      snap_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      tag_q <= tag_d;
      pay_q <= pay_d;
      cnt_q <= cnt_d;
      snap_q <= snap_d;
      drop_q <= drop_d;
    end
  end
endmodule

// File: tb/tb_dbg_trace_tx.sv
// tb_dbg_trace_tx: table-driven vectors plus scoreboarded byte stream for dbg_trace_tx.
module tb_dbg_trace_tx;
  typedef struct {
    logic [1:0]  valid;
    logic [15:0] d0;
    logic [15:0] d1;
    int          loss;
  } vec_t;
  localparam int DEPTH = 32;
  logic clk = 1'b0, resetn = 1'b0, tx_wait = 1'b0;
  logic [1:0] dbg_valid = '0;
  logic [31:0] dbg_data = '0;
  logic tx_we, idle;
  logic [7:0] tx_data, drop_cnt;
  logic [5:0] level;
  logic v5 = 1'b0;
  logic [39:0] d5 = '0;
  logic we5, idle5;
  logic [7:0] data5, drop5;
  logic [2:0] level5;
  int n_vec = 0, n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] q5[$];
  string hexs = "0123456789abcdef";
  vec_t vt[8];

  always #5 clk = ~clk;

  dbg_trace_tx u_dut (
    .clk(clk), .resetn(resetn), .dbg_valid(dbg_valid), .dbg_data(dbg_data),
    .tx_we(tx_we), .tx_data(tx_data), .tx_wait(tx_wait), .idle(idle),
    .level(level), .drop_cnt(drop_cnt)
  );

  dbg_trace_tx #(.NCHAN(1), .DATA_W(40), .DEPTH(4), .SEP_CHAR(8'h00)) u_wide (
    .clk(clk), .resetn(resetn), .dbg_valid(v5), .dbg_data(d5),
    .tx_we(we5), .tx_data(data5), .tx_wait(1'b0), .idle(idle5),
    .level(level5), .drop_cnt(drop5)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] hx(input logic [3:0] n);
    return hexs[n];
  endfunction

  task automatic expect_rec(input logic [15:0] d);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(hx(d[7:4]));
    exp_q.push_back(hx(d[3:0]));
    exp_q.push_back(8'h0a);
  endtask

  task automatic expect_mark(input logic [7:0] n);
`ifdef DBG_DROPMARK_EN
    exp_q.push_back(8'h21);
    exp_q.push_back(hx(n[7:4]));
    exp_q.push_back(hx(n[3:0]));
    exp_q.push_back(8'h0a);
`else
    if (n == 8'hff) exp_q.push_back(8'h00);
`endif
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    @(negedge clk);
    while (!(idle && idle5) && t < 400) begin
      @(negedge clk);
      t++;
    end
    check({nm, " idle"}, {31'd0, idle && idle5}, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 resetn = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
  endtask

  always @(negedge clk) begin
    if (resetn && tx_we && !tx_wait) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL byte: unexpected 0x%02h, none expected", tx_data);
      end else check("byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (resetn && we5) begin
      if (q5.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL wide byte: unexpected 0x%02h, none expected", data5);
      end else check("wide byte", {24'd0, data5}, {24'd0, q5.pop_front()});
    end
  end

  initial begin
    int cum;
    int t;
    logic [15:0] w;
    logic [7:0] idx;
    logic [39:0] rec5;
    vt[0] = '{2'b01, 16'h413c, 16'h0000, 0};
    vt[1] = '{2'b11, 16'h4b01, 16'h4c02, 1};
    vt[2] = '{2'b10, 16'h0000, 16'h5a9f, 0};
    vt[3] = '{2'b01, 16'h7eff, 16'h0000, 0};
    vt[4] = '{2'b11, 16'h3000, 16'h31ab, 1};
    vt[5] = '{2'b10, 16'h0000, 16'h23e0, 0};
    vt[6] = '{2'b01, 16'h2e55, 16'h0000, 0};
    vt[7] = '{2'b11, 16'h6112, 16'h6234, 1};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst tx_we", {31'd0, tx_we}, 32'd0);
    check("rst tx_data", {24'd0, tx_data}, 32'd0);
    check("rst level", {26'd0, level}, 32'd0);
    check("rst drop", {24'd0, drop_cnt}, 32'd0);
    check("rst idle", {31'd0, idle}, 32'd1);
    @(posedge clk); #1 resetn = 1'b1;
    // first-record latency: push in cycle N, load N+1, tx_we in N+2
    @(posedge clk); #1;
    dbg_valid = 2'b01;
    dbg_data = {16'h0000, 16'h413c};
    expect_rec(16'h413c);
    @(negedge clk);
    check("lat0 we", {31'd0, tx_we}, 32'd0);
    @(posedge clk); #1 dbg_valid = '0;
    @(negedge clk);
    check("lat1 we", {31'd0, tx_we}, 32'd0);
    check("lat1 level", {26'd0, level}, 32'd1);
    check("lat1 idle", {31'd0, idle}, 32'd0);
    @(negedge clk);
    check("lat2 we", {31'd0, tx_we}, 32'd1);
    check("lat2 data", {24'd0, tx_data}, 32'h41);
    check("lat2 level", {26'd0, level}, 32'd0);
    wait_idle("t1");
    check("t1 drained", exp_q.size(), 0);
    cum = 0;
    for (int i = 0; i < 8; i++) begin
      w = vt[i].valid[0] ? vt[i].d0 : vt[i].d1;
      @(posedge clk); #1;
      dbg_valid = vt[i].valid;
      dbg_data = {vt[i].d1, vt[i].d0};
      expect_rec(w);
`ifdef DBG_DROPMARK_EN
      if (vt[i].loss > 0) expect_mark(8'(vt[i].loss));
`else
      cum += vt[i].loss;
`endif
      @(posedge clk); #1 dbg_valid = '0;
      wait_idle("vec");
      check("vec drop", {24'd0, drop_cnt}, cum);
      check("vec drained", exp_q.size(), 0);
    end
    // overflow: formatter holds one record, FIFO fills to DEPTH, last 3 dropped
    do_reset();
    @(posedge clk); #1;
    tx_wait = 1'b1;
    dbg_valid = 2'b01;
    dbg_data = {16'h0000, 16'h5000};
    expect_rec(16'h5000);
    expect_mark(8'd3);
    @(posedge clk); #1 dbg_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 1; i <= DEPTH + 3; i++) begin
      idx = 8'(i);
      dbg_valid = 2'b01;
      dbg_data = {16'h0000, 8'h50, idx};
      if (i <= DEPTH) expect_rec({8'h50, idx});
      @(posedge clk); #1;
    end
    dbg_valid = '0;
    @(negedge clk);
    check("ovf level", {26'd0, level}, DEPTH);
    check("ovf drop", {24'd0, drop_cnt}, 3);
    check("ovf we held", {31'd0, tx_we}, 32'd1);
    check("ovf data held", {24'd0, tx_data}, 32'h50);
    @(posedge clk); #1 tx_wait = 1'b0;
    wait_idle("ovf");
`ifdef DBG_DROPMARK_EN
    check("ovf drop after", {24'd0, drop_cnt}, 0);
`else
    check("ovf drop after", {24'd0, drop_cnt}, 3);
`endif
    check("ovf drained", exp_q.size(), 0);
    // reset mid-record while the uart is stalled
    @(posedge clk); #1;
    dbg_valid = 2'b01;
    dbg_data = {16'h0000, 16'h413c};
    exp_q.push_back(8'h41);
    @(posedge clk); #1 dbg_data = {16'h0000, 16'h4e7a};
    @(posedge clk); #1 dbg_valid = '0;
    t = 0;
    while (!(tx_we && tx_data == 8'h33) && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("rst6 reach hex", {24'd0, tx_data}, 32'h33);
    check("rst6 level pre", {26'd0, level}, 32'd1);
    tx_wait = 1'b1;
    resetn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst6 we", {31'd0, tx_we}, 32'd0);
    check("rst6 level", {26'd0, level}, 32'd0);
    check("rst6 idle", {31'd0, idle}, 32'd1);
    check("rst6 drop", {24'd0, drop_cnt}, 32'd0);
    check("rst6 drained", exp_q.size(), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    tx_wait = 1'b0;
    @(posedge clk); #1;
    dbg_valid = 2'b10;
    dbg_data = {16'h4e7a, 16'h0000};
    expect_rec(16'h4e7a);
    @(posedge clk); #1 dbg_valid = '0;
    wait_idle("rst6 clean");
    check("rst6 clean drained", exp_q.size(), 0);
    // wide record, no separator
    rec5 = 40'h58_deadbeef;
    q5.push_back(rec5[39:32]);
    for (int i = 7; i >= 0; i--) q5.push_back(hx(rec5[i*4 +: 4]));
    @(posedge clk); #1;
    v5 = 1'b1;
    d5 = rec5;
    @(posedge clk); #1 v5 = 1'b0;
    wait_idle("wide");
    check("wide drained", q5.size(), 0);
    check("wide drop", {24'd0, drop5}, 32'd0);
    check("final drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
